// File: rtl/enemy_bullet_hit_scanner.sv
// Sequential player-vs-enemy-bullet collision scanner: snapshots one frame, tests one slot per
// clock against a rectangular hitbox, then applies the lives / invincibility / game-over policy.
module enemy_bullet_hit_scanner #(
  parameter int unsigned N_BULLETS  = 8,
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 9,
  parameter int unsigned HIT_DX     = 12,
  parameter int unsigned HIT_DY     = 12,
  parameter int unsigned IFRAMES    = 60,
  parameter int unsigned LIVES_INIT = 3
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           i_Start,
  input  logic [X_W+Y_W-1:0]             i_PlayerPos,
  input  logic [N_BULLETS*(X_W+Y_W)-1:0] i_BulletPos,
  input  logic [N_BULLETS-1:0]           i_BulletValid,
  output logic                           o_Busy,
  output logic                           o_Done,
  output logic [N_BULLETS-1:0]           o_HitMask,
  output logic                           o_Hit,
  output logic [3:0]                     o_Lives,
  output logic                           o_Invincible,
  output logic                           o_GameOver
);

  localparam int unsigned PW = X_W + Y_W;
  localparam int unsigned IW = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;
  localparam int unsigned CW = $clog2(IFRAMES + 1);

  typedef enum logic [1:0] {StIdle, StScan, StReport} state_e;

  state_e                       state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [PW-1:0]                ppos_q, ppos_d;
  logic [N_BULLETS*PW-1:0]      bpos_q, bpos_d;
  logic [N_BULLETS-1:0]         bvalid_q, bvalid_d;
  logic [N_BULLETS-1:0]         wmask_q, wmask_d;
  logic [N_BULLETS-1:0]         hitmask_q, hitmask_d;
  logic [3:0]                   lives_q, lives_d;
  logic [CW-1:0]                icnt_q, icnt_d;
  logic                         gameover_q, gameover_d;
  logic                         hit_q, hit_d;

  logic [31:0]          slot_base;
  logic [PW-1:0]        slot;
  logic [X_W-1:0]       bx, px, dx;
  logic [Y_W-1:0]       by, py, dy;
  logic                 overlap;
  logic [N_BULLETS-1:0] final_mask;
  logic                 damage;

  // Distances are max - min at full width so no wrap-around or sign issues can occur.
  always_comb begin
    slot_base  = 32'(idx_q) * PW;
    slot       = bpos_q[slot_base +: PW];
    bx         = slot[PW-1 -: X_W];
    by         = slot[Y_W-1:0];
    px         = ppos_q[PW-1 -: X_W];
    py         = ppos_q[Y_W-1:0];
    dx         = (bx >= px) ? (bx - px) : (px - bx);
    dy         = (by >= py) ? (by - py) : (py - by);
    overlap    = bvalid_q[idx_q] && (32'(dx) <= HIT_DX) && (32'(dy) <= HIT_DY);
    final_mask = wmask_q;
    if (overlap) begin
      final_mask[idx_q] = 1'b1;
    end
    damage     = (|final_mask) && (icnt_q == '0) && !gameover_q;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ppos_d     = ppos_q;
    bpos_d     = bpos_q;
    bvalid_d   = bvalid_q;
    wmask_d    = wmask_q;
    hitmask_d  = hitmask_q;
    lives_d    = lives_q;
    icnt_d     = icnt_q;
    gameover_d = gameover_q;
    hit_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_Start) begin
          ppos_d   = i_PlayerPos;
          bpos_d   = i_BulletPos;
          bvalid_d = i_BulletValid;
          idx_d    = '0;
          wmask_d  = '0;
          state_d  = StScan;
        end
      end
      StScan: begin
        wmask_d = final_mask;
        idx_d   = idx_q + IW'(1);
        // Results are registered on the edge into the report cycle so they line up with o_Done.
        if (idx_q == IW'(N_BULLETS - 1)) begin
          state_d   = StReport;
          hitmask_d = final_mask;
          if (damage) begin
            hit_d   = 1'b1;
            lives_d = lives_q - 4'd1;
            icnt_d  = CW'(IFRAMES);
            if (lives_q == 4'd1) begin
              gameover_d = 1'b1;
            end
          end else if (icnt_q != '0) begin
            icnt_d = icnt_q - CW'(1);
          end
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      ppos_q     <= '0;
      bpos_q     <= '0;
      bvalid_q   <= '0;
      wmask_q    <= '0;
      hitmask_q  <= '0;
      lives_q    <= 4'(LIVES_INIT);
      icnt_q     <= '0;
      gameover_q <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ppos_q     <= ppos_d;
      bpos_q     <= bpos_d;
      bvalid_q   <= bvalid_d;
      wmask_q    <= wmask_d;
      hitmask_q  <= hitmask_d;
      lives_q    <= lives_d;
      icnt_q     <= icnt_d;
      gameover_q <= gameover_d;
      hit_q      <= hit_d;
    end
  end

  assign o_Busy       = (state_q != StIdle);
  assign o_Done       = (state_q == StReport);
  assign o_Hit        = hit_q;
  assign o_HitMask    = hitmask_q;
  assign o_Lives      = lives_q;
  assign o_Invincible = (icnt_q != '0);
  assign o_GameOver   = gameover_q;

endmodule

// File: tb/tb_enemy_bullet_hit_scanner.sv
// Self-checking bench: directed scenarios plus randomized frames, compared every cycle against a
// timing-window model of the scanner's results and damage policy.
module tb_enemy_bullet_hit_scanner;

  localparam int N   = 8;
  localparam int XW  = 10;
  localparam int YW  = 9;
  localparam int PW  = XW + YW;
  localparam int HDX = 12;
  localparam int HDY = 12;
  localparam int IFR = 60;
  localparam int LIV = 3;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          Start = 1'b0;
  logic [PW-1:0]   ppos = '0;
  logic [N*PW-1:0] bpos = '0;
  logic [N-1:0]    bval = '0;

  logic          o_Busy, o_Done, o_Hit, o_Invincible, o_GameOver;
  logic [N-1:0]  o_HitMask;
  logic [3:0]    o_Lives;

  always #5 Clk = ~Clk;

  enemy_bullet_hit_scanner #(
    .N_BULLETS(N), .X_W(XW), .Y_W(YW), .HIT_DX(HDX), .HIT_DY(HDY),
    .IFRAMES(IFR), .LIVES_INIT(LIV)
  ) dut (
    .Clk(Clk), .Rst(Rst), .i_Start(Start), .i_PlayerPos(ppos), .i_BulletPos(bpos),
    .i_BulletValid(bval), .o_Busy(o_Busy), .o_Done(o_Done), .o_HitMask(o_HitMask),
    .o_Hit(o_Hit), .o_Lives(o_Lives), .o_Invincible(o_Invincible), .o_GameOver(o_GameOver)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int           cyc = 0;
  int           m_s = -1000;  // edge at which the current/last scan was accepted
  logic [N-1:0] m_pend = '0, m_mask = '0;
  int           m_lives = LIV, m_icnt = 0;
  bit           m_go = 0, m_hit = 0, m_done = 0, m_busy = 0;

  function automatic logic [N-1:0] hits_of();
    logic [N-1:0] m = '0;
    int px = int'(ppos[YW +: XW]);
    int py = int'(ppos[0 +: YW]);
    for (int k = 0; k < N; k++) begin
      int bx = int'(bpos[k*PW+YW +: XW]);
      int by = int'(bpos[k*PW +: YW]);
      int ax = (bx > px) ? bx - px : px - bx;
      int ay = (by > py) ? by - py : py - by;
      if (bval[k] && ax <= HDX && ay <= HDY) m[k] = 1'b1;
    end
    return m;
  endfunction

  always @(posedge Clk) begin
    cyc++;
    if (Rst) begin
      m_s = -1000; m_pend = '0; m_mask = '0; m_lives = LIV; m_icnt = 0;
      m_go = 0; m_hit = 0; m_done = 0; m_busy = 0;
    end else begin
      m_hit = 0; m_done = 0;
      if (Start && cyc >= m_s + N + 2) begin
        m_s = cyc;
        m_pend = hits_of();
      end
      if (cyc == m_s + N) begin
        m_done = 1;
        m_mask = m_pend;
        if (m_pend != 0 && m_icnt == 0 && !m_go) begin
          m_hit = 1;
          m_lives = m_lives - 1;
          m_icnt = IFR;
          if (m_lives == 0) m_go = 1;
        end else if (m_icnt > 0) begin
          m_icnt = m_icnt - 1;
        end
      end
      m_busy = (cyc >= m_s && cyc <= m_s + N);
    end
  end

  always @(negedge Clk) begin
    check("cyc_busy", o_Busy, m_busy);
    check("cyc_done", o_Done, m_done);
    check("cyc_hit", o_Hit, m_hit);
    check("cyc_mask", o_HitMask, m_mask);
    check("cyc_lives", o_Lives, m_lives);
    check("cyc_inv", o_Invincible, m_icnt != 0);
    check("cyc_gameover", o_GameOver, m_go);
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_player(input int x, input int y);
    ppos = {XW'(x), YW'(y)};
  endtask

  task automatic set_slot(input int k, input int x, input int y);
    bpos[k*PW +: PW] = {XW'(x), YW'(y)};
  endtask

  task automatic single_hit_setup();
    set_player(200, 200);
    for (int k = 0; k < N; k++) set_slot(k, 900, 450);
    set_slot(0, 205, 195);
    bval = 8'h01;
  endtask

  task automatic scan(output bit got_hit, output logic [N-1:0] got_mask, output bit got_inv);
    int lat = -1;
    @(negedge Clk); #1 Start = 1'b1;
    @(negedge Clk); #1 Start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (o_Done) begin lat = i; break; end
    end
    check("scan_latency", lat, N - 1);
    got_hit = o_Hit; got_mask = o_HitMask; got_inv = o_Invincible;
  endtask

  bit           h, iv;
  logic [N-1:0] mk;
  int           hit_cnt, nz_cnt, done_cnt, done_at;
  bit           h1, h62, inv60, inv61;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values, and a start that arrives while reset is still high
    repeat (3) @(negedge Clk);
    check("rst_busy", o_Busy, 0);
    check("rst_lives", o_Lives, 3);
    check("rst_mask", o_HitMask, 0);
    check("rst_inv", o_Invincible, 0);
    check("rst_gameover", o_GameOver, 0);
    #1 Start = 1'b1;
    @(negedge Clk);
    check("start_in_reset_busy", o_Busy, 0);
    #1 Rst = 1'b0; Start = 1'b0;

    // single hit
    single_hit_setup();
    scan(h, mk, iv);
    check("single_hit", h, 1);
    check("single_mask", mk, 8'h01);
    check("single_lives", o_Lives, 2);
    check("single_inv", iv, 1);

    // boundary and invalid slots
    for (int k = 0; k < N; k++) set_slot(k, 900, 450);
    set_slot(1, 212, 188);
    set_slot(2, 213, 200);
    set_slot(3, 200, 200);
    bval = 8'b0000_0110;
    scan(h, mk, iv);
    check("boundary_mask", mk, 8'h02);
    check("boundary_hit_while_inv", h, 0);

    // near-origin player: real hit at {0,0}, and a slot that would match only with wraparound
    set_player(5, 5);
    set_slot(0, 0, 0);
    set_slot(1, 1017, 505);
    bval = 8'h03;
    scan(h, mk, iv);
    check("wrap_mask", mk, 8'h01);

    // reset mid-scan
    single_hit_setup();
    @(negedge Clk); #1 Start = 1'b1;
    @(negedge Clk); #1 Start = 1'b0;
    @(negedge Clk); @(negedge Clk);
    #1 Rst = 1'b1;
    #1;
    check("midrst_busy", o_Busy, 0);
    check("midrst_done", o_Done, 0);
    check("midrst_lives", o_Lives, 3);
    check("midrst_mask", o_HitMask, 0);
    check("midrst_inv", o_Invincible, 0);
    repeat (2) @(negedge Clk);
    #1 Rst = 1'b0;
    scan(h, mk, iv);
    check("post_rst_hit", h, 1);
    check("post_rst_mask", mk, 8'h01);
    check("post_rst_lives", o_Lives, 2);

    // invincibility window, from a fresh reset
    @(negedge Clk); #1 Rst = 1'b1;
    @(negedge Clk); #1 Rst = 1'b0;
    hit_cnt = 0; nz_cnt = 0;
    for (int s = 1; s <= 62; s++) begin
      scan(h, mk, iv);
      hit_cnt += int'(h);
      nz_cnt += int'(mk != 0);
      if (s == 1) h1 = h;
      if (s == 62) h62 = h;
      if (s == 60) inv60 = iv;
      if (s == 61) inv61 = iv;
    end
    check("iframe_hit_scan1", h1, 1);
    check("iframe_hit_scan62", h62, 1);
    check("iframe_hit_count", hit_cnt, 2);
    check("iframe_mask_nonzero", nz_cnt, 62);
    check("iframe_inv_scan60", inv60, 1);
    check("iframe_inv_scan61", inv61, 0);
    check("iframe_lives", o_Lives, 1);

    // run down to game over, then confirm it sticks
    for (int s = 0; s < 61; s++) scan(h, mk, iv);
    check("gameover_last_hit", h, 1);
    check("gameover_lives", o_Lives, 0);
    check("gameover_flag", o_GameOver, 1);
    hit_cnt = 0;
    for (int s = 0; s < 65; s++) begin
      scan(h, mk, iv);
      hit_cnt += int'(h);
    end
    check("after_go_hits", hit_cnt, 0);
    check("after_go_lives", o_Lives, 0);
    check("after_go_mask", mk, 8'h01);

    // start while busy is ignored; start right after the report cycle is accepted
    @(negedge Clk); #1 Start = 1'b1;          // cycle T
    @(negedge Clk); #1 Start = 1'b0;          // cycle T+1
    done_cnt = 0; done_at = -1;
    for (int c = 2; c <= 11; c++) begin
      @(negedge Clk);
      if (o_Done) begin done_cnt++; done_at = c; end
      if (c == 3) begin #1 Start = 1'b1; end
      if (c == 4) begin #1 Start = 1'b0; end
      if (c == 10) begin #1 Start = 1'b1; end
      if (c == 11) begin
        check("restart_busy", o_Busy, 1);
        #1 Start = 1'b0;
      end
    end
    check("busy_start_done_count", done_cnt, 1);
    check("busy_start_done_at", done_at, 9);
    repeat (12) @(negedge Clk);

    // randomized frames with random starts and occasional resets
    @(negedge Clk); #1 Rst = 1'b1;
    @(negedge Clk); #1 Rst = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      int px, py;
      @(negedge Clk); #1;
      px = int'($urandom_range(0, 1023));
      py = int'($urandom_range(0, 511));
      set_player(px, py);
      for (int k = 0; k < N; k++) begin
        int bx = px + int'($urandom_range(0, 40)) - 20;
        int by = py + int'($urandom_range(0, 40)) - 20;
        if (bx < 0) bx = 0;
        if (bx > 1023) bx = 1023;
        if (by < 0) by = 0;
        if (by > 511) by = 511;
        set_slot(k, bx, by);
      end
      bval  = 8'($urandom);
      Start = ($urandom_range(0, 3) == 0);
      Rst   = ($urandom_range(0, 399) == 0);
    end
    @(negedge Clk); #1 Rst = 1'b0; Start = 1'b0;
    repeat (12) @(negedge Clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
